// File: rtl/mem_load_unit.sv
// Load unit: issues a word-aligned read, waits READ_LATENCY cycles, captures into the MDR and extracts byte/half/word.
// Optional macro LOAD_ALIGN_CHECK_EN flags misaligned half/word loads on ld_err and skips the memory read.
module mem_load_unit #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ld_start,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  ld_size,
    input  logic        ld_signed,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ld_data,
    output logic        ld_done,
    output logic        ld_busy,
    output logic        ld_err
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, CAPT, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(READ_LATENCY - 1);

    state_t      state_q;
    logic [31:0] mem_addr_q;
    logic        mem_rd_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [1:0]  off_q;
    logic [3:0]  cnt_q;
    logic [31:0] mdr_q;
    logic [31:0] mdr_d;
    logic [31:0] ld_data_q;
    logic        done_q;
    logic        busy_q;
    logic        err_q;

    // Big-endian lane select: byte offset 0 is the most significant byte.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic sgn, input logic [1:0] off);
        logic signed [15:0] h;
        logic signed [7:0]  b;
        logic [31:0]        r;
        h = off[1] ? w[15:0] : w[31:16];
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        case (sz)
            2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'h0000, h};
            2'b10:   r = sgn ? {{24{b[7]}}, b} : {24'h000000, b};
            default: r = w;
        endcase
        return r;
    endfunction

`ifdef LOAD_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [1:0] a, input logic [1:0] sz);
        logic m;
        case (sz)
            2'b01:   m = a[0];
            2'b10:   m = 1'b0;
            default: m = (a != 2'b00);
        endcase
        return m;
    endfunction
`endif

    always_comb begin
        mdr_d = (state_q == CAPT) ? mem_rdata : mdr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            size_q     <= '0;
            sgn_q      <= 1'b0;
            off_q      <= '0;
            cnt_q      <= '0;
            mdr_q      <= '0;
            ld_data_q  <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            mem_rd_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            mdr_q    <= mdr_d;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (ld_start) begin
                        mem_addr_q <= {ld_addr[31:2], 2'b00};
                        size_q     <= ld_size;
                        sgn_q      <= ld_signed;
                        off_q      <= ld_addr[1:0];
                        busy_q     <= 1'b1;
`ifdef LOAD_ALIGN_CHECK_EN
                        if (misaligned(ld_addr[1:0], ld_size)) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            err_q     <= 1'b1;
                            ld_data_q <= '0;
                        end else begin
                            state_q  <= REQ;
                            mem_rd_q <= 1'b1;
                        end
`else
                        state_q  <= REQ;
                        mem_rd_q <= 1'b1;
`endif
                    end
                end
                REQ: begin
                    if (READ_LATENCY == 1) begin
                        state_q <= CAPT;
                    end else begin
                        cnt_q   <= CNT_LOAD;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= CAPT;
                    end
                end
                CAPT: begin
                    ld_data_q <= extract(mdr_d, size_q, sgn_q, off_q);
                    done_q    <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_rd   = mem_rd_q;
    assign ld_data  = ld_data_q;
    assign ld_done  = done_q;
    assign ld_busy  = busy_q;
    assign ld_err   = err_q;

endmodule

// File: doc/mem_load_unit.md
Name: mem_load_unit

Overview:
- Read-side counterpart of the memory write-data path.
- Control unit issues a load request.
- The block drives a word-aligned read to data memory and waits a fixed memory latency.
- It then captures the returned word into an internal MDR, extracts byte/half/word with sign or zero extension, and returns the result with a one-cycle done pulse.
- Sits between the control FSM / address register and the data memory, feeding the register-file write-data mux.

Parameters:
READ_LATENCY, 1, cycles from the mem_rd cycle to the cycle mem_rdata is valid (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
ld_start  input  1  load request, sampled on rising edge; ignored while busy
ld_addr  input  32  byte address of the load
ld_size  input  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
ld_signed  input  1  1 sign-extends half/byte, 0 zero-extends
mem_addr  output  32  word-aligned read address, {addr[31:2],2'b00}
mem_rd  output  1  memory read strobe, exactly one cycle per load
mem_rdata  input  32  memory read data, valid READ_LATENCY cycles after mem_rd cycle
ld_data  output  32  extended load result, held until next accepted start
ld_done  output  1  one-cycle pulse, ld_data valid
ld_busy  output  1  high from the cycle after acceptance through the done cycle
ld_err  output  1  misalignment flag (see Optional Feature), valid with ld_done

Behaviour:
- Reset (async, reset_n=0):
  - state IDLE.
  - mem_addr, mem_rd, ld_data, ld_done, ld_busy, ld_err = 0.
  - Internal MDR, latched size/sign/offset and counter = 0.
  - Reset mid-operation abandons the load; any later mem_rdata is ignored.
- FSM states: IDLE, REQ, WAIT, CAPT, DONE.
- IDLE:
  - On ld_start=1 at edge: latch addr, size, signed → REQ.
  - ld_busy=0.
- REQ (1 cycle):
  - mem_rd=1, mem_addr=aligned latched addr.
  - Counter loaded with READ_LATENCY-1 → WAIT, or → CAPT if READ_LATENCY=1.
- WAIT:
  - mem_rd=0; mem_addr held.
  - Counter decrements each cycle; at 0 → CAPT.
- CAPT (1 cycle):
  - mem_rdata is valid this cycle; MDR <= mem_rdata at the closing edge → DONE.
- DONE (1 cycle):
  - ld_done=1; ld_data=extract(MDR) (registered, stable from this cycle).
  - → IDLE.
  - ld_start in DONE is ignored; earliest accepted restart is the cycle after DONE.
- Latency: start sampled at edge 0 → mem_rd high cycle 1 → data captured end of cycle 1+L → ld_done in cycle 2+L. With L=1, done in cycle 3.
- Extraction (big-endian; byte offset 0 = bits [31:24]):
  - word: MDR.
  - half: offset[1]=0 → [31:16], 1 → [15:0].
  - byte: offset 0..3 → [31:24], [23:16], [15:8], [7:0].
  - Extension to 32 bits per the latched ld_signed; ld_signed is ignored for word.
- ld_start while ld_busy=1: ignored, no queueing.
- ld_data retains its last value after DONE until the next load completes.

Optional Feature:
- Macro LOAD_ALIGN_CHECK_EN.
- Defined:
  - Misaligned requests are detected in IDLE at acceptance: half with addr[0]=1, word/reserved with addr[1:0]≠0.
  - Misaligned request → skip REQ/WAIT/CAPT, go straight to DONE; mem_rd never asserted.
  - In that DONE cycle: ld_err=1, ld_data=0. Done occurs in cycle 1 after the start edge.
  - Aligned loads: ld_err=0.
- Undefined:
  - ld_err tied 0; no checks.
  - Word ignores addr[1:0]; half ignores addr[0].

Test Plan:
- Reset mid-WAIT (READ_LATENCY=3, reset_n low in cycle 2) → all outputs 0 immediately; later mem_rdata ignored; next load behaves normally.
- Word load, L=1, ld_addr=0x0000_0104, mem_rdata=0xDEAD_BEEF → mem_rd high only in cycle 1 with mem_addr=0x104; ld_done in cycle 3 with ld_data=0xDEADBEEF.
- Signed byte, ld_addr=0x0000_0103, mem_rdata=0x1122_3380 → ld_data=0xFFFF_FF80; unsigned → 0x0000_0080; mem_addr=0x100.
- Half, ld_addr=0x0000_0202, mem_rdata=0x1234_8001, L=4 → ld_done in cycle 6; signed → 0xFFFF_8001, unsigned → 0x0000_8001.
- ld_start held high for 10 cycles, L=1 → loads accepted at edges 0 and 4 only; ld_busy high in cycles 1–3 and 5–7; exactly one mem_rd per load.
- With LOAD_ALIGN_CHECK_EN, word at 0x0000_0102 → no mem_rd; ld_done in cycle 1 with ld_err=1, ld_data=0. Without the macro → normal read of 0x100, ld_err=0.
